// File: rtl/core_sequencer_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: opcodes, FSM states,
// the reset NOP and the legal-opcode check used in DECODE.
package core_sequencer_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_REG    = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } seq_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] RESET_NOP = 32'h0000_0013;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_REG, OP_IMM, OP_AUIPC, OP_LUI: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_next_pc.sv
// Next-PC select for EXECUTE: jump/taken-branch target or sequential PC,
// plus the alignment check that sends a bad target to TRAP.
module next_pc_unit
  import core_sequencer_pkg::*;
(
  input  opcode_e     opcode_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  logic        branch_taken_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  // Sequential PC wraps naturally at 2^32.
  always_comb begin
    next_pc_o = pc_i + 32'd4;
    case (opcode_i)
      OP_JAL, OP_JALR: next_pc_o = target_i;
      OP_BRANCH:       if (branch_taken_i) next_pc_o = target_i;
      default:         ;
    endcase
  end

  assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I datapath. Owns PC, IR
// and the retired-instruction counter; drives imem/dmem request handshakes.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  // Must be 4-byte aligned.
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned INSTRET_WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_ready_i,
  input  logic [31:0]              imem_rdata_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  input  logic                     dmem_ready_i,
  output opcode_e                  opcode_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  input  logic                     write_enable_i,
  input  logic                     branch_taken_i,
  input  logic [31:0]              target_i,
  output logic                     rf_we_o,
  output logic                     trap_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  seq_state_e               state_q, state_d;
  logic [31:0]              pc_q;
  logic [31:0]              ir_q;
  logic [31:0]              next_pc_q;
  logic [31:0]              next_pc;
  logic                     misaligned;
  logic [INSTRET_WIDTH-1:0] instret_q;
  opcode_e                  opcode;

  assign opcode = opcode_e'(ir_q[6:0]);

  next_pc_unit u_next_pc (
    .opcode_i       (opcode),
    .pc_i           (pc_q),
    .target_i       (target_i),
    .branch_taken_i (branch_taken_i),
    .next_pc_o      (next_pc),
    .misaligned_o   (misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Strobes decode from state only, so *_ready_i never reaches *_req_o.
  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    trap_o     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = is_legal_opcode(ir_q[6:0]) ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        if (misaligned)
          state_d = ST_TRAP;
        else if (opcode == OP_LOAD || opcode == OP_STORE)
          state_d = ST_MEMORY;
        else
          state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (opcode == OP_STORE);
        if (dmem_ready_i) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we_o = write_enable_i;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        trap_o  = 1'b1;
        state_d = ST_TRAP;
      end
      default: state_d = ST_TRAP;
    endcase
  end

  // PC only moves in WRITEBACK, so a misaligned target leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      ir_q      <= RESET_NOP;
      next_pc_q <= RESET_PC;
      instret_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready_i) ir_q <= imem_rdata_i;
        end
        ST_EXECUTE: begin
          if (!misaligned) next_pc_q <= next_pc;
        end
        ST_WRITEBACK: begin
          pc_q      <= next_pc_q;
          instret_q <= instret_q + INSTRET_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = ir_q;
  assign opcode_o    = opcode;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a per-instruction timeline model predicts every
// cycle's outputs; a second instance covers PC wrap and instret wrap.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o, imem_ready_i, dmem_req_o, dmem_we_o, dmem_ready_i;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, target_i;
  opcode_e     opcode_o;
  logic        write_enable_i, branch_taken_i, rf_we_o, trap_o;
  logic [63:0] instret_o;

  logic        rst2;
  logic        imem_req2, dmem_req2, dmem_we2, rf_we2, trap2;
  logic [31:0] imem_addr2, instr2, pc2;
  opcode_e     opcode2;
  logic [1:0]  instret2;

  int n_compared = 0;
  int n_mismatched = 0;

  logic        e_valid = 1'b0;
  logic        e_imem_req, e_dmem_req, e_dmem_we, e_rf_we;
  logic [31:0] m_pc, m_ir;
  logic [63:0] m_instret;
  logic        m_trap;

  always #5 clk = ~clk;

  core_sequencer dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i),
    .opcode_o(opcode_o), .instr_o(instr_o), .pc_o(pc_o),
    .write_enable_i(write_enable_i), .branch_taken_i(branch_taken_i),
    .target_i(target_i), .rf_we_o(rf_we_o), .trap_o(trap_o),
    .instret_o(instret_o)
  );

  core_sequencer #(.RESET_PC(32'hFFFF_FFFC), .INSTRET_WIDTH(2)) dut_wrap (
    .clk_i(clk), .rst_i(rst2),
    .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
    .imem_ready_i(1'b1), .imem_rdata_i(32'h0010_0093),
    .dmem_req_o(dmem_req2), .dmem_we_o(dmem_we2), .dmem_ready_i(1'b0),
    .opcode_o(opcode2), .instr_o(instr2), .pc_o(pc2),
    .write_enable_i(1'b1), .branch_taken_i(1'b0),
    .target_i(32'h0), .rf_we_o(rf_we2), .trap_o(trap2),
    .instret_o(instret2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model's predicted outputs.
  always @(negedge clk) begin
    if (e_valid) begin
      checkOutput("imem_req",  imem_req_o,  e_imem_req);
      checkOutput("imem_addr", imem_addr_o, m_pc);
      checkOutput("dmem_req",  dmem_req_o,  e_dmem_req);
      checkOutput("dmem_we",   dmem_we_o,   e_dmem_we);
      checkOutput("rf_we",     rf_we_o,     e_rf_we);
      checkOutput("trap",      trap_o,      m_trap);
      checkOutput("pc",        pc_o,        m_pc);
      checkOutput("instr",     instr_o,     m_ir);
      checkOutput("opcode",    opcode_o,    m_ir[6:0]);
      checkOutput("instret",   instret_o,   m_instret);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs the DUT must ignore outside the matching state.
  task automatic drive_noise();
    imem_ready_i   = 1'b1;
    imem_rdata_i   = 32'hDEAD_BEEF;
    dmem_ready_i   = 1'b1;
    write_enable_i = 1'b1;
    branch_taken_i = 1'b1;
    target_i       = 32'h0000_0001;
  endtask

  task automatic set_exp(input logic ireq, input logic dreq, input logic dwe, input logic rfwe);
    e_imem_req = ireq;
    e_dmem_req = dreq;
    e_dmem_we  = dwe;
    e_rf_we    = rfwe;
  endtask

  task automatic do_reset();
    drive_noise();
    rst_i   = 1'b1;
    e_valid = 1'b0;
    step();
    rst_i     = 1'b0;
    m_pc      = 32'h0;
    m_ir      = 32'h0000_0013;
    m_instret = 64'd0;
    m_trap    = 1'b0;
    e_valid   = 1'b1;
  endtask

  // Plays one instruction through the DUT and predicts each cycle.
  task automatic applyStimulus(input logic [31:0] instr, input int fw, input int mw,
                               input logic taken, input logic [31:0] target,
                               input logic we, output int ncyc);
    logic [6:0]  opc;
    logic [31:0] np;
    ncyc = 0;
    opc  = instr[6:0];
    for (int i = 0; i <= fw; i++) begin
      drive_noise();
      imem_ready_i = (i == fw);
      imem_rdata_i = (i == fw) ? instr : 32'hFFFF_FFFF;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      step(); ncyc++;
    end
    m_ir = instr;
    drive_noise();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    step(); ncyc++;
    if (!(opc inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h17, 7'h37})) begin
      m_trap = 1'b1;
      return;
    end
    drive_noise();
    branch_taken_i = taken;
    target_i       = target;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    step(); ncyc++;
    if (opc == 7'h6F || opc == 7'h67 || (opc == 7'h63 && taken)) np = target;
    else np = m_pc + 32'd4;
    if (np[1:0] != 2'b00) begin
      m_trap = 1'b1;
      return;
    end
    if (opc == 7'h03 || opc == 7'h23) begin
      for (int i = 0; i <= mw; i++) begin
        drive_noise();
        dmem_ready_i = (i == mw);
        set_exp(1'b0, 1'b1, opc == 7'h23, 1'b0);
        step(); ncyc++;
      end
    end
    drive_noise();
    write_enable_i = we;
    set_exp(1'b0, 1'b0, 1'b0, we);
    step(); ncyc++;
    m_pc      = np;
    m_instret = m_instret + 64'd1;
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_noise();
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ncyc;
    rst2 = 1'b1;
    rst_i = 1'b1;
    drive_noise();
    step();
    do_reset();

    checkOutput("reset_pc",      pc_o,       32'h0);
    checkOutput("reset_ir",      instr_o,    32'h0000_0013);
    checkOutput("reset_trap",    trap_o,     1'b0);
    checkOutput("reset_instret", instret_o,  64'd0);
    checkOutput("reset_imemreq", imem_req_o, 1'b1);

    applyStimulus(32'h0010_0093, 0, 0, 1'b0, 32'h0, 1'b1, ncyc);
    checkOutput("addi_cycles",  ncyc,      4);
    checkOutput("addi_pc",      pc_o,      32'h4);
    checkOutput("addi_instret", instret_o, 64'd1);

    applyStimulus(32'h0020_2223, 0, 3, 1'b0, 32'h0, 1'b0, ncyc);
    checkOutput("sw_cycles", ncyc, 8);
    checkOutput("sw_pc",     pc_o, 32'h8);

    applyStimulus(32'h0000_2183, 2, 0, 1'b0, 32'h0, 1'b1, ncyc);
    checkOutput("lw_cycles", ncyc, 7);
    checkOutput("lw_pc",     pc_o, 32'hC);

    applyStimulus(32'h0000_0063, 0, 0, 1'b1, 32'h100, 1'b0, ncyc);
    checkOutput("beq_taken_pc", pc_o, 32'h100);
    applyStimulus(32'h0000_0063, 0, 0, 1'b0, 32'h200, 1'b0, ncyc);
    checkOutput("beq_not_taken_pc", pc_o, 32'h104);

    applyStimulus(32'h0000_006F, 0, 0, 1'b0, 32'h40, 1'b1, ncyc);
    checkOutput("jal_pc",      pc_o,      32'h40);
    checkOutput("jal_instret", instret_o, 64'd6);

    applyStimulus(32'h0000_006F, 0, 0, 1'b0, 32'h102, 1'b1, ncyc);
    trap_cycles(6);
    checkOutput("jal_misaligned_trap", trap_o,     1'b1);
    checkOutput("jal_misaligned_pc",   pc_o,       32'h40);
    checkOutput("trap_no_fetch",       imem_req_o, 1'b0);

    do_reset();
    applyStimulus(32'h0000_0000, 0, 0, 1'b0, 32'h0, 1'b1, ncyc);
    trap_cycles(4);
    checkOutput("illegal_trap",   trap_o, 1'b1);
    checkOutput("illegal_cycles", ncyc,   2);

    do_reset();
    applyStimulus(32'h0010_0093, 1, 0, 1'b0, 32'h0, 1'b1, ncyc);
    checkOutput("pre_reset_pc", pc_o, 32'h4);
    do_reset();
    checkOutput("midfetch_reset_pc",   pc_o,    32'h0);
    checkOutput("midfetch_reset_ir",   instr_o, 32'h0000_0013);
    checkOutput("midfetch_reset_trap", trap_o,  1'b0);
    applyStimulus(32'h0000_0037, 0, 0, 1'b0, 32'h0, 1'b1, ncyc);

    e_valid = 1'b0;
    rst2 = 1'b0;
    repeat (4) step();
    checkOutput("wrap_pc",        pc2,      32'h0);
    checkOutput("wrap_instret1",  instret2, 2'd1);
    repeat (8) step();
    checkOutput("wrap_instret_max", instret2, 2'd3);
    checkOutput("wrap_pc3",         pc2,      32'h8);
    repeat (4) step();
    checkOutput("wrap_instret0", instret2, 2'd0);
    checkOutput("wrap_pc4",      pc2,      32'hC);
    checkOutput("wrap_trap",     trap2,    1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the single-issue RV32I datapath through fetch, decode, execute, memory and writeback. It owns the PC and instruction register and drives the instruction and data memory request handshakes. It gates register-file writes using the per-opcode write enable from the control unit, and maintains a retired-instruction counter. It sits between the memory interfaces and the control unit / ALU / register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
INSTRET_WIDTH, 64, width of the retired-instruction counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  32  fetch address; equals pc_o
imem_ready_i  in  1  fetch complete; imem_rdata_i valid this cycle
imem_rdata_i  in  32  fetched instruction
dmem_req_o  out  1  data access request
dmem_we_o  out  1  data access is a store
dmem_ready_i  in  1  data access complete
opcode_o  out  opcode_e  opcode field of the instruction register (IR[6:0]); feeds the control unit
instr_o  out  32  instruction register
pc_o  out  32  current PC
write_enable_i  in  1  register-file write enable from the control unit for opcode_o
branch_taken_i  in  1  branch comparator result, valid in EXECUTE
target_i  in  32  ALU result used as jump/branch target, valid in EXECUTE
rf_we_o  out  1  register-file write strobe
trap_o  out  1  sticky fault indication
instret_o  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset (synchronous, rst_i high at the clock edge): state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (NOP), instret=0, trap_o=0, all strobes 0. Reset wins over every other event in the same cycle, including an in-flight memory handshake. No request is held across reset.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - On imem_ready_i: IR<=imem_rdata_i, go to DECODE.
  - Otherwise stay, holding req and addr stable.
- DECODE: one cycle, register-file read.
  - If opcode is not in {OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_REG, OP_IMM, OP_AUIPC, OP_LUI}, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - Latch next_pc:
    - target_i for OP_JAL and OP_JALR;
    - target_i for OP_BRANCH with branch_taken_i=1;
    - pc+4 otherwise (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
  - If next_pc[1:0]!=0, go to TRAP; pc is not updated.
  - Else go to MEMORY for OP_LOAD/OP_STORE, WRITEBACK otherwise.
- MEMORY:
  - dmem_req_o=1, dmem_we_o=(opcode==OP_STORE), both held stable until dmem_ready_i.
  - On ready, go to WRITEBACK.
  - dmem_ready_i is ignored in every other state.
- WRITEBACK: one cycle.
  - rf_we_o=write_enable_i (so branches and stores never write).
  - pc<=next_pc, instret<=instret+1 (wraps to 0 at max), go to FETCH.
- TRAP:
  - trap_o=1, all strobes 0, pc and IR frozen.
  - Only rst_i exits.
- Latency with zero memory wait: 4 cycles for non-memory instructions, 5 for loads/stores, plus 1 per wait cycle.
- imem_ready_i asserted while not in FETCH is ignored.
- rf_we_o and dmem_req_o are never high outside WRITEBACK and MEMORY respectively.
- All outputs are registered or decoded purely from state/IR; no combinational path from *_ready_i to *_req_o.

Decomposition:
- Shared package: the state enum (seq_state_e), the RESET_NOP constant, and the legal-opcode check function alongside opcode_e.
- Natural sub-module: next_pc_unit (combinational next-PC select and alignment check). Everything else stays in core_sequencer.

Test Plan:
- Reset then ADDI (32'h0010_0093), imem_ready_i=1 immediately -> imem_addr_o=0; rf_we_o pulses in cycle 4; pc_o=4; instret_o=1.
- SW with dmem_ready_i delayed 3 cycles -> dmem_req_o=1 and dmem_we_o=1 held for 4 cycles; rf_we_o stays 0; pc advances by 4; total 8 cycles.
- BEQ with branch_taken_i=1, target_i=32'h100 -> pc_o=32'h100, rf_we_o=0. Repeat with branch_taken_i=0 -> pc_o=pc+4.
- JAL with target_i=32'h102 -> TRAP; trap_o=1; pc unchanged; no further imem_req_o until reset.
- Illegal opcode 7'b0000000 -> TRAP after DECODE; rst_i mid-FETCH with imem_ready_i held -> pc_o=RESET_PC, IR=NOP, trap_o=0.
- RESET_PC=32'hFFFF_FFFC, one ADDI -> pc wraps to 0. Force instret to all-ones -> wraps to 0 on the next retire.
